// File: rtl/perceptron_train_ctrl.sv
// Training sequencer for the FP16 perceptron datapath; owns weights w0..w2.
// Optional `PTC_EARLY_STOP_EN`: end the run at the first zero-error epoch.
module perceptron_train_ctrl #(
    parameter int NS        = 4,
    parameter int DP_LAT    = 2,
    parameter int MAX_EPOCH = 16,
    parameter int EW        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              w0_init,
    input  logic [15:0]              w1_init,
    input  logic [15:0]              w2_init,
    input  logic [15:0]              d_sample,
    input  logic [15:0]              y_act,
    input  logic [15:0]              w0_new,
    input  logic [15:0]              w1_new,
    input  logic [15:0]              w2_new,
    output logic [$clog2(NS)-1:0]    sample_idx,
    output logic                     dp_en,
    output logic [15:0]              w0,
    output logic [15:0]              w1,
    output logic [15:0]              w2,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic [EW-1:0]            epoch_count,
    output logic [$clog2(NS+1)-1:0]  last_err
);

    localparam int IW = $clog2(NS);
    localparam int EC = $clog2(NS + 1);
    localparam int WW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NS - 1);
    localparam logic [WW-1:0] W_LAST   = WW'(DP_LAT - 1);
    localparam logic [EW:0]   EP_LAST  = (EW + 1)'(MAX_EPOCH);

`ifdef PTC_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic [EC-1:0] err;
    logic          mismatch;
    logic [EW:0]   ep_inc;
    logic [EW-1:0] ep_sat;

    assign mismatch = (y_act != d_sample);
    assign ep_inc   = {1'b0, epoch_count} + (EW + 1)'(1);
    // Saturate rather than wrap so a long run never reports a small count.
    assign ep_sat   = (&epoch_count) ? epoch_count : ep_inc[EW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            err         <= '0;
            sample_idx  <= '0;
            dp_en       <= 1'b0;
            w0          <= 16'h0000;
            w1          <= 16'h0000;
            w2          <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch_count <= '0;
            last_err    <= '0;
        end else if (abort && state != S_IDLE) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            dp_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    w0          <= w0_init;
                    w1          <= w1_init;
                    w2          <= w2_init;
                    sample_idx  <= '0;
                    epoch_count <= '0;
                    err         <= '0;
                    wcnt        <= '0;
                    converged   <= 1'b0;
                    dp_en       <= 1'b1;
                    state       <= S_EVAL;
                end
                S_EVAL: begin
                    if (wcnt == W_LAST) begin
                        wcnt  <= '0;
                        state <= S_UPDATE;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                S_UPDATE: begin
                    if (mismatch) begin
                        w0  <= w0_new;
                        w1  <= w1_new;
                        w2  <= w2_new;
                        err <= err + EC'(1);
                    end
                    if (sample_idx == IDX_LAST) begin
                        dp_en <= 1'b0;
                        state <= S_CHECK;
                    end else begin
                        sample_idx <= sample_idx + IW'(1);
                        state      <= S_EVAL;
                    end
                end
                S_CHECK: begin
                    epoch_count <= ep_sat;
                    last_err    <= err;
                    if (EARLY_STOP && err == '0) begin
                        converged <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else if (ep_inc == EP_LAST) begin
                        converged <= (err == '0);
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        sample_idx <= '0;
                        err        <= '0;
                        dp_en      <= 1'b1;
                        state      <= S_EVAL;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    dp_en <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl with a behavioural datapath model.
// Covers both the early-stop and full-run builds of the controller.
module tb_perceptron_train_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] w0_init, w1_init, w2_init;
    logic [15:0] d_sample, y_act, w0_new, w1_new, w2_new;
    logic [1:0]  sample_idx;
    logic        dp_en, busy, done, converged;
    logic [7:0]  epoch_count;
    logic [2:0]  last_err;
    logic [15:0] w0, w1, w2;

    int mode;
    int n_chk = 0;
    int n_err = 0;
    int cyc;
    bit saw_done;

    perceptron_train_ctrl #(
        .NS(4), .DP_LAT(2), .MAX_EPOCH(8), .EW(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
        .d_sample(d_sample), .y_act(y_act),
        .w0_new(w0_new), .w1_new(w1_new), .w2_new(w2_new),
        .sample_idx(sample_idx), .dp_en(dp_en),
        .w0(w0), .w1(w1), .w2(w2),
        .busy(busy), .done(done), .converged(converged),
        .epoch_count(epoch_count), .last_err(last_err)
    );

    always #5 clk = ~clk;

    // Datapath model: mode 0 always right, 1 wrong only on
    // sample 2 of epoch 0, 2 always wrong (weights step by +1).
    logic mism;
    always_comb begin
        d_sample = sample_idx[0] ? 16'h3C00 : 16'h0000;
        mism = (mode == 2) ||
               (mode == 1 && sample_idx == 2'd2 && epoch_count == 8'd0);
        y_act = mism ? (d_sample ^ 16'h3C00) : d_sample;
        w0_new = 16'h7E00;
        w1_new = 16'h7E00;
        w2_new = 16'h7E00;
        if (mode == 1) begin
            w0_new = 16'h3800;
            w1_new = 16'h3800;
            w2_new = 16'h3800;
        end else if (mode == 2) begin
            w0_new = w0 + 16'd1;
            w1_new = w1 + 16'd1;
            w2_new = w2 + 16'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic kick();
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        while (!done && cyc < limit) step();
    endtask

    task automatic set_init(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c);
        w0_init = a;
        w1_init = b;
        w2_init = c;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        set_init(16'h3C00, 16'h0000, 16'hBC00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_w0", w0, 16'h0);
        check("rst_w2", w2, 16'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_conv", converged, 0);
        check("rst_ep", epoch_count, 0);
        check("rst_lerr", last_err, 0);
        check("rst_dpen", dp_en, 0);

        // start and abort together while idle: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        check("sa_idle_busy", busy, 0);

`ifdef PTC_EARLY_STOP_EN
        mode = 0;
        kick();
        check("t2_load_busy", busy, 1);
        wait_done(300);
        check("t2_lat", cyc, 15);
        check("t2_ep", epoch_count, 1);
        check("t2_lerr", last_err, 0);
        check("t2_conv", converged, 1);
        check("t2_w0", w0, 16'h3C00);
        check("t2_w1", w1, 16'h0000);
        check("t2_w2", w2, 16'hBC00);
        step();

        mode = 1;
        kick();
        while (cyc < 10) step();
        check("t3_w0_pre", w0, 16'h3C00);
        step();
        check("t3_w0_upd", w0, 16'h3800);
        check("t3_w2_upd", w2, 16'h3800);
        while (cyc < 15) step();
        check("t3_ep0_lerr", last_err, 1);
        check("t3_ep0_cnt", epoch_count, 1);
        wait_done(300);
        check("t3_lat", cyc, 28);
        check("t3_ep", epoch_count, 2);
        check("t3_lerr", last_err, 0);
        check("t3_conv", converged, 1);
        step();
`else
        mode = 0;
        kick();
        check("t6_dpen_load", dp_en, 0);
        step();
        check("t6_dpen_eval", dp_en, 1);
        wait_done(300);
        check("t6_lat", cyc, 106);
        check("t6_ep", epoch_count, 8);
        check("t6_lerr", last_err, 0);
        check("t6_conv", converged, 1);
        check("t6_w0", w0, 16'h3C00);
        check("t6_w2", w2, 16'hBC00);
        step();
        check("t6_done_pulse", done, 0);
        check("t6_conv_hold", converged, 1);
`endif

        mode = 2;
        set_init(16'h3C00, 16'h0000, 16'hBC00);
        kick();
        wait_done(300);
        check("t4_lat", cyc, 106);
        check("t4_ep", epoch_count, 8);
        check("t4_lerr", last_err, 4);
        check("t4_conv", converged, 0);
        check("t4_w0", w0, 16'h3C20);
        check("t4_w1", w1, 16'h0020);
        check("t4_w2", w2, 16'hBC20);
        step();
        check("t4_idle", busy, 0);

        mode = 2;
        kick();
        while (cyc < 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 15) step();
        check("t5_ep1", epoch_count, 1);
        check("t5_busy", busy, 1);
        check("t5_w0_ep0", w0, 16'h3C04);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_ab_busy", busy, 0);
        check("t5_ab_dpen", dp_en, 0);
        check("t5_ab_done", done, 0);
        check("t5_ab_conv", converged, 0);
        check("t5_ab_w0", w0, 16'h3C04);
        check("t5_ab_w1", w1, 16'h0004);
        check("t5_ab_w2", w2, 16'hBC04);
        saw_done = 1'b0;
        repeat (20) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("t5_no_done", saw_done, 0);

        mode = 0;
        set_init(16'h1111, 16'h2222, 16'h3333);
        kick();
        check("t5_re_busy", busy, 1);
        step();
        check("t5_re_w0", w0, 16'h1111);
        check("t5_re_w2", w2, 16'h3333);
        check("t5_re_ep", epoch_count, 0);
        wait_done(300);
        check("t5_re_done", done, 1);
        check("t5_re_conv", converged, 1);
        step();

        mode = 2;
        kick();
        while (cyc < 20) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_w0", w0, 16'h0);
        check("mr_w1", w1, 16'h0);
        check("mr_busy", busy, 0);
        check("mr_ep", epoch_count, 0);
        check("mr_lerr", last_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
